// File: rtl/syndrome_fetch_pkg.sv
// -----------------------------------------------------------------------------
// syndrome_fetch_pkg
//   Shared definitions for the syndrome fetch sequencer:
//     - GF_W_DEFAULT : default Galois-field symbol width of one syndrome
//     - ST_*         : sequencer state encoding
//     - CODE_T4      : code selector value of the t=4 code (S1..S8 valid)
//     - cfg_t        : per-codeword configuration frozen at the first bundle
//     - bundle_count : number of switch bundles that make up one codeword
// -----------------------------------------------------------------------------
package syndrome_fetch_pkg;

    localparam int GF_W_DEFAULT = 10;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;  // waiting for the first bundle
    localparam logic [2:0] ST_HOLD_A = 3'd1;  // presenting the first set of a bundle
    localparam logic [2:0] ST_HOLD_B = 3'd2;  // presenting the upper half (t=2 Chase)
    localparam logic [2:0] ST_REQ    = 3'd3;  // one-cycle next-pattern request
    localparam logic [2:0] ST_WAIT   = 3'd4;  // waiting for the requested bundle

    localparam logic [1:0] CODE_T4 = 2'b10;

    typedef struct packed {
        logic       mode;  // 0 = hard decision, 1 = soft/Chase
        logic [1:0] code;  // CODE_T4 or one of the t=2 codes
    } cfg_t;

    // Hard decision needs one bundle; Chase with t=4 carries one pattern per
    // bundle (4 bundles); Chase with t=2 packs two patterns per bundle (2 bundles).
    function automatic logic [2:0] bundle_count(input logic mode, input logic [1:0] code);
        if (!mode) begin
            return 3'd1;
        end else if (code == CODE_T4) begin
            return 3'd4;
        end else begin
            return 3'd2;
        end
    endfunction

endpackage

// File: rtl/syndrome_fetch_bundle_reg.sv
// -----------------------------------------------------------------------------
// syn_bundle_reg
//   Enabled capture register for one 8 x GF_W syndrome bundle. Alongside the
//   data it registers two zero flags, one per half of the bundle, so the
//   consumer can report "all presented syndromes are zero" for either the
//   full set (S1..S8), the lower half (S1..S4) or the upper half (S5..S8)
//   in the same cycle the data appears.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   load     in   capture d on this edge
//   d        in   bundle, S1 in the least significant GF_W bits
//   q        out  captured bundle
//   zero_lo  out  captured S1..S4 are all zero
//   zero_hi  out  captured S5..S8 are all zero
// -----------------------------------------------------------------------------
module syn_bundle_reg
    import syndrome_fetch_pkg::*;
#(
    parameter int GF_W = GF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [8*GF_W-1:0] d,
    output logic [8*GF_W-1:0] q,
    output logic              zero_lo,
    output logic              zero_hi
);

    // NOTE: the bundle storage is reset along with the control state so that
    // the syndrome outputs come out of reset at a defined all-zero value.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            zero_lo <= 1'b0;
            zero_hi <= 1'b0;
        end else if (load) begin
            q       <= d;
            zero_lo <= (d[4*GF_W-1:0] == '0);
            zero_hi <= (d[8*GF_W-1:4*GF_W] == '0);
        end
    end

endmodule

// File: rtl/syndrome_fetch.sv
// -----------------------------------------------------------------------------
// syndrome_fetch
//   Consumer-side sequencer between the syndrome switch and the key-equation
//   solver. A bundle is captured on the switch's one-cycle i_valid pulse and
//   split into per-test-pattern syndrome sets that are offered downstream with
//   a valid/ready handshake. Between bundles a one-cycle o_next_tp pulse asks
//   the switch for the next bundle until every pattern has been delivered.
//
// Ports:
//   i_clk, i_rst_n   clock / synchronous active-low reset
//   i_mode           0 = hard decision (1 pattern), 1 = Chase (4 patterns)
//   i_code           CODE_T4 = t=4 code, other values = t=2 codes
//   i_S1..i_S8       syndrome bundle from the switch
//   i_valid          one-cycle pulse, bundle valid
//   o_next_tp        one-cycle request for the next bundle
//   o_S1..o_S8       syndromes of the presented pattern
//   o_tp_idx         test-pattern index of the presented set
//   o_zero           every presented syndrome is zero
//   o_valid          set presented, held until accepted
//   i_ready          solver accepts when o_valid && i_ready
//   o_done           one-cycle pulse after the final pattern is accepted
//   o_err            sticky: bundle arrived while a set was being presented
// -----------------------------------------------------------------------------
module syndrome_fetch
    import syndrome_fetch_pkg::*;
#(
    parameter int GF_W = GF_W_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mode,
    input  logic [1:0]      i_code,
    input  logic [GF_W-1:0] i_S1,
    input  logic [GF_W-1:0] i_S2,
    input  logic [GF_W-1:0] i_S3,
    input  logic [GF_W-1:0] i_S4,
    input  logic [GF_W-1:0] i_S5,
    input  logic [GF_W-1:0] i_S6,
    input  logic [GF_W-1:0] i_S7,
    input  logic [GF_W-1:0] i_S8,
    input  logic            i_valid,
    output logic            o_next_tp,
    output logic [GF_W-1:0] o_S1,
    output logic [GF_W-1:0] o_S2,
    output logic [GF_W-1:0] o_S3,
    output logic [GF_W-1:0] o_S4,
    output logic [GF_W-1:0] o_S5,
    output logic [GF_W-1:0] o_S6,
    output logic [GF_W-1:0] o_S7,
    output logic [GF_W-1:0] o_S8,
    output logic [1:0]      o_tp_idx,
    output logic            o_zero,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_done,
    output logic            o_err
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    cfg_t              cfg;
    logic [1:0]        bundle_cnt;
    logic [1:0]        tp_idx;
    logic              done_q;
    logic              err_q;

    logic              in_hold;
    logic              accept;
    logic              take;
    logic              split;
    logic              last_bundle;

    logic [8*GF_W-1:0] bundle_d;
    logic [8*GF_W-1:0] bundle_q;
    logic              zero_lo;
    logic              zero_hi;

    logic [GF_W-1:0]   show [8];
    logic              show_zero;

    // ------------------------------------------------------------------
    // Handshake and bundle bookkeeping
    // ------------------------------------------------------------------
    assign in_hold = (state == ST_HOLD_A) || (state == ST_HOLD_B);
    assign accept  = in_hold && i_ready;

    // A bundle is taken in IDLE, WAIT and also in REQ: the request has
    // already gone out, so an early reply from the switch is still valid.
    assign take    = i_valid && ((state == ST_IDLE) || (state == ST_WAIT) || (state == ST_REQ));

    // Chase with a t=2 code carries two patterns per bundle.
    assign split   = cfg.mode && (cfg.code != CODE_T4);

    assign last_bundle = (({1'b0, bundle_cnt} + 3'd1) == bundle_count(cfg.mode, cfg.code));

    assign bundle_d = {i_S8, i_S7, i_S6, i_S5, i_S4, i_S3, i_S2, i_S1};

    syn_bundle_reg #(
        .GF_W (GF_W)
    ) u_bundle (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (take),
        .d       (bundle_d),
        .q       (bundle_q),
        .zero_lo (zero_lo),
        .zero_hi (zero_hi)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_valid) state_nxt = ST_HOLD_A;
            end
            ST_HOLD_A: begin
                if (i_ready) begin
                    if (split)            state_nxt = ST_HOLD_B;
                    else if (last_bundle) state_nxt = ST_IDLE;
                    else                  state_nxt = ST_REQ;
                end
            end
            ST_HOLD_B: begin
                if (i_ready) state_nxt = last_bundle ? ST_IDLE : ST_REQ;
            end
            ST_REQ: begin
                state_nxt = i_valid ? ST_HOLD_A : ST_WAIT;
            end
            ST_WAIT: begin
                if (i_valid) state_nxt = ST_HOLD_A;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cfg        <= '0;
            bundle_cnt <= '0;
            tp_idx     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_nxt;

            // Only an accept that drops back to IDLE ends the codeword.
            done_q <= accept && (state_nxt == ST_IDLE);

            // A bundle arriving while a set is held would overwrite live data;
            // it is dropped and the condition latched until reset.
            if (i_valid && in_hold) err_q <= 1'b1;

            if ((state == ST_IDLE) && i_valid) begin
                cfg        <= '{mode: i_mode, code: i_code};
                bundle_cnt <= '0;
                tp_idx     <= '0;
            end

            if (state == ST_REQ) bundle_cnt <= bundle_cnt + 2'd1;

            // Every non-final accept moves to the next test pattern, whether
            // it is the upper half of this bundle or the next bundle.
            if (accept && (state_nxt != ST_IDLE)) tp_idx <= tp_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Presented set: selected half/full bundle, zeros elsewhere
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            show[k] = '0;
        end
        show_zero = 1'b0;

        if (state == ST_HOLD_A) begin
            for (int k = 0; k < 4; k++) begin
                show[k] = bundle_q[k*GF_W +: GF_W];
            end
            // S5..S8 exist only in the t=4 code.
            if (cfg.code == CODE_T4) begin
                for (int k = 4; k < 8; k++) begin
                    show[k] = bundle_q[k*GF_W +: GF_W];
                end
            end
            show_zero = zero_lo && (zero_hi || (cfg.code != CODE_T4));
        end else if (state == ST_HOLD_B) begin
            // Second pattern of a t=2 Chase bundle lives in the upper half.
            for (int k = 0; k < 4; k++) begin
                show[k] = bundle_q[(k+4)*GF_W +: GF_W];
            end
            show_zero = zero_hi;
        end
    end

    assign o_S1      = show[0];
    assign o_S2      = show[1];
    assign o_S3      = show[2];
    assign o_S4      = show[3];
    assign o_S5      = show[4];
    assign o_S6      = show[5];
    assign o_S7      = show[6];
    assign o_S8      = show[7];
    assign o_zero    = show_zero;
    assign o_tp_idx  = tp_idx;
    assign o_valid   = in_hold;
    assign o_next_tp = (state == ST_REQ);
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_syndrome_fetch.sv
// -----------------------------------------------------------------------------
// tb_syndrome_fetch
//   Directed bench for syndrome_fetch. Inputs change and outputs are read on
//   the falling edge; the DUT acts on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_syndrome_fetch;

    localparam int GF_W = 10;
    localparam int BW   = 8 * GF_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_mode;
    logic [1:0]      i_code;
    logic [GF_W-1:0] i_S1, i_S2, i_S3, i_S4, i_S5, i_S6, i_S7, i_S8;
    logic            i_valid;
    logic            i_ready;
    logic            o_next_tp;
    logic [GF_W-1:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
    logic [1:0]      o_tp_idx;
    logic            o_zero;
    logic            o_valid;
    logic            o_done;
    logic            o_err;

    int checks = 0;
    int errors = 0;
    int ntp_cnt = 0;
    int done_cnt = 0;

    syndrome_fetch #(.GF_W(GF_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_mode    (i_mode),
        .i_code    (i_code),
        .i_S1      (i_S1),
        .i_S2      (i_S2),
        .i_S3      (i_S3),
        .i_S4      (i_S4),
        .i_S5      (i_S5),
        .i_S6      (i_S6),
        .i_S7      (i_S7),
        .i_S8      (i_S8),
        .i_valid   (i_valid),
        .o_next_tp (o_next_tp),
        .o_S1      (o_S1),
        .o_S2      (o_S2),
        .o_S3      (o_S3),
        .o_S4      (o_S4),
        .o_S5      (o_S5),
        .o_S6      (o_S6),
        .o_S7      (o_S7),
        .o_S8      (o_S8),
        .o_tp_idx  (o_tp_idx),
        .o_zero    (o_zero),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    // Pulse counters; sampled on the rising edge so they never race the
    // falling-edge stimulus.
    always @(posedge clk) begin
        if (o_next_tp) ntp_cnt++;
        if (o_done)    done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // {valid, next_tp, done, err}
    function automatic logic [3:0] st();
        return {o_valid, o_next_tp, o_done, o_err};
    endfunction

    function automatic logic [BW-1:0] shown();
        return {o_S8, o_S7, o_S6, o_S5, o_S4, o_S3, o_S2, o_S1};
    endfunction

    // Expected set: S1..S8 = base .. base+7
    function automatic logic [BW-1:0] sv8(input int base);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*GF_W +: GF_W] = GF_W'(base + k);
        return v;
    endfunction

    // Expected set: S1..S4 = base .. base+3, S5..S8 = 0
    function automatic logic [BW-1:0] lo4(input int base);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*GF_W +: GF_W] = GF_W'(base + k);
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic mode, input logic [1:0] code, input logic [BW-1:0] b);
        i_mode  = mode;
        i_code  = code;
        {i_S8, i_S7, i_S6, i_S5, i_S4, i_S3, i_S2, i_S1} = b;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_mode = 1'b0; i_code = 2'b00;
        {i_S8, i_S7, i_S6, i_S5, i_S4, i_S3, i_S2, i_S1} = '0;
        tick(); tick();
        checks++; if (st() !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", st()); end
        checks++; if (shown() !== '0) begin errors++; $display("FAIL reset_data got %h want 0", shown()); end
        checks++; if ({o_tp_idx, o_zero} !== 3'b000) begin errors++; $display("FAIL reset_idx_zero got %b want 000", {o_tp_idx, o_zero}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mode0();
        int n0;
        n0 = ntp_cnt;
        i_ready = 1'b1;
        drive(1'b0, 2'b10, sv8(1));
        checks++; if (st() !== 4'b1000) begin errors++; $display("FAIL m0_status got %b want 1000", st()); end
        checks++; if (shown() !== sv8(1)) begin errors++; $display("FAIL m0_data got %h want %h", shown(), sv8(1)); end
        checks++; if ({o_tp_idx, o_zero} !== 3'b000) begin errors++; $display("FAIL m0_idx_zero got %b want 000", {o_tp_idx, o_zero}); end
        tick();
        checks++; if (st() !== 4'b0010) begin errors++; $display("FAIL m0_done got %b want 0010", st()); end
        tick();
        checks++; if (st() !== 4'b0000) begin errors++; $display("FAIL m0_done_pulse got %b want 0000", st()); end
        checks++; if (ntp_cnt != n0) begin errors++; $display("FAIL m0_no_next_tp got %0d want %0d", ntp_cnt, n0); end
    endtask

    task automatic test_chase_t2();
        int n0, d0;
        n0 = ntp_cnt; d0 = done_cnt;
        i_ready = 1'b1;
        drive(1'b1, 2'b00, sv8(1));
        checks++; if ({st(), o_tp_idx} !== 6'b1000_00) begin errors++; $display("FAIL t2_p0_status got %b want 100000", {st(), o_tp_idx}); end
        checks++; if (shown() !== lo4(1)) begin errors++; $display("FAIL t2_p0_data got %h want %h", shown(), lo4(1)); end
        tick();
        checks++; if ({st(), o_tp_idx} !== 6'b1000_01) begin errors++; $display("FAIL t2_p1_status got %b want 100001", {st(), o_tp_idx}); end
        checks++; if (shown() !== lo4(5)) begin errors++; $display("FAIL t2_p1_data got %h want %h", shown(), lo4(5)); end
        tick();
        checks++; if (st() !== 4'b0100) begin errors++; $display("FAIL t2_req got %b want 0100", st()); end
        tick();
        checks++; if (st() !== 4'b0000) begin errors++; $display("FAIL t2_wait got %b want 0000", st()); end
        drive(1'b1, 2'b00, sv8(9));
        checks++; if ({st(), o_tp_idx} !== 6'b1000_10) begin errors++; $display("FAIL t2_p2_status got %b want 100010", {st(), o_tp_idx}); end
        checks++; if (shown() !== lo4(9)) begin errors++; $display("FAIL t2_p2_data got %h want %h", shown(), lo4(9)); end
        tick();
        checks++; if ({st(), o_tp_idx} !== 6'b1000_11) begin errors++; $display("FAIL t2_p3_status got %b want 100011", {st(), o_tp_idx}); end
        checks++; if (shown() !== lo4(13)) begin errors++; $display("FAIL t2_p3_data got %h want %h", shown(), lo4(13)); end
        tick();
        checks++; if (st() !== 4'b0010) begin errors++; $display("FAIL t2_done got %b want 0010", st()); end
        tick();
        checks++; if (ntp_cnt - n0 != 1) begin errors++; $display("FAIL t2_next_tp_count got %0d want 1", ntp_cnt - n0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t2_done_count got %0d want 1", done_cnt - d0); end
    endtask

    // Four bundles, each stalled one cycle; bundles 1..3 arrive in the
    // request cycle itself.
    task automatic test_chase_t4_stall();
        int n0;
        n0 = ntp_cnt;
        i_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 2'b10, sv8(16 * (b + 1)));
            checks++; if ({st(), o_tp_idx} !== {4'b1000, 2'(b)}) begin errors++; $display("FAIL t4_b%0d_status got %b want %b", b, {st(), o_tp_idx}, {4'b1000, 2'(b)}); end
            checks++; if (shown() !== sv8(16 * (b + 1))) begin errors++; $display("FAIL t4_b%0d_data got %h want %h", b, shown(), sv8(16 * (b + 1))); end
            tick();
            checks++; if ({st(), o_tp_idx} !== {4'b1000, 2'(b)} || shown() !== sv8(16 * (b + 1))) begin errors++; $display("FAIL t4_b%0d_stall got %b/%h want %b/%h", b, {st(), o_tp_idx}, shown(), {4'b1000, 2'(b)}, sv8(16 * (b + 1))); end
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            if (b < 3) begin
                checks++; if (st() !== 4'b0100) begin errors++; $display("FAIL t4_b%0d_req got %b want 0100", b, st()); end
            end else begin
                checks++; if (st() !== 4'b0010) begin errors++; $display("FAIL t4_done got %b want 0010", st()); end
            end
        end
        tick();
        checks++; if (ntp_cnt - n0 != 3) begin errors++; $display("FAIL t4_next_tp_count got %0d want 3", ntp_cnt - n0); end
    endtask

    task automatic test_zero();
        logic [BW-1:0] b;
        i_ready = 1'b1;
        drive(1'b0, 2'b10, '0);
        checks++; if ({o_valid, o_zero} !== 2'b11) begin errors++; $display("FAIL zero_all got %b want 11", {o_valid, o_zero}); end
        tick(); tick();
        b = '0; b[7*GF_W +: GF_W] = 10'd3;
        drive(1'b0, 2'b00, b);
        checks++; if ({o_valid, o_zero} !== 2'b11) begin errors++; $display("FAIL zero_s8_hidden got %b want 11", {o_valid, o_zero}); end
        checks++; if (shown() !== '0) begin errors++; $display("FAIL zero_s8_data got %h want 0", shown()); end
        tick(); tick();
        b = '0; b[0 +: GF_W] = 10'd7;
        drive(1'b1, 2'b01, b);
        checks++; if ({o_valid, o_zero, shown()} !== {2'b10, b}) begin errors++; $display("FAIL zero_t2_lo got %b/%h want 10/%h", {o_valid, o_zero}, shown(), b); end
        tick();
        checks++; if ({o_valid, o_zero, o_tp_idx} !== 4'b1101) begin errors++; $display("FAIL zero_t2_hi got %b want 1101", {o_valid, o_zero, o_tp_idx}); end
        tick();
        drive(1'b1, 2'b01, '0);
        checks++; if ({o_valid, o_zero, o_tp_idx} !== 4'b1110) begin errors++; $display("FAIL zero_t2_b1 got %b want 1110", {o_valid, o_zero, o_tp_idx}); end
        tick(); tick();
        checks++; if (st() !== 4'b0010) begin errors++; $display("FAIL zero_t2_done got %b want 0010", st()); end
        tick();
    endtask

    task automatic test_err();
        i_ready = 1'b0;
        drive(1'b0, 2'b10, sv8(1));
        drive(1'b0, 2'b10, sv8(50));
        checks++; if ({st(), o_tp_idx} !== 6'b1001_00) begin errors++; $display("FAIL err_set got %b want 100100", {st(), o_tp_idx}); end
        checks++; if (shown() !== sv8(1)) begin errors++; $display("FAIL err_ignored got %h want %h", shown(), sv8(1)); end
        i_ready = 1'b1;
        tick();
        checks++; if (st() !== 4'b0011) begin errors++; $display("FAIL err_done got %b want 0011", st()); end
        tick();
        checks++; if (st() !== 4'b0001) begin errors++; $display("FAIL err_sticky got %b want 0001", st()); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        drive(1'b1, 2'b10, sv8(100));
        tick();
        checks++; if (st() !== 4'b0101) begin errors++; $display("FAIL rm_req got %b want 0101", st()); end
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if ({st(), o_tp_idx, o_zero} !== 7'b0) begin errors++; $display("FAIL rm_status got %b want 0000000", {st(), o_tp_idx, o_zero}); end
        checks++; if (shown() !== '0) begin errors++; $display("FAIL rm_data got %h want 0", shown()); end
        rst_n = 1'b1;
        i_ready = 1'b0;
        drive(1'b1, 2'b10, sv8(200));
        checks++; if ({st(), o_tp_idx} !== 6'b1000_00) begin errors++; $display("FAIL rm_restart got %b want 100000", {st(), o_tp_idx}); end
        checks++; if (shown() !== sv8(200)) begin errors++; $display("FAIL rm_restart_data got %h want %h", shown(), sv8(200)); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_chase_t2();
        test_chase_t4_stall();
        test_zero();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syndrome_fetch.md
# syndrome_fetch

Consumer-side sequencer for the Chase/BCH syndrome path. It sits between the syndrome switch and the key-equation solver. It captures each syndrome bundle on the switch's one-cycle valid pulse and splits it into per-test-pattern syndrome sets. Each set is presented downstream with a valid/ready handshake, and the block pulses next-pattern requests back to the switch until every test pattern of the codeword has been delivered.

## Interface
Parameters:
- GF_W, 10, Galois-field symbol width of each syndrome.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  reset: synchronous, active-low. Clock is i_clk.
- i_mode  in  1  0 = hard decision (1 pattern), 1 = soft/Chase (4 patterns).
- i_code  in  2  2'b10 = t=4 code (S1..S8 valid); 2'b00/2'b01 = t=2 codes (S1..S4 per pattern).
- i_S1..i_S8  in  GF_W each  syndrome bundle from the switch.
- i_valid  in  1  one-cycle pulse: bundle on i_S* is valid.
- o_next_tp  out  1  one-cycle pulse requesting the next bundle.
- o_S1..o_S8  out  GF_W each  syndromes of the presented pattern.
- o_tp_idx  out  2  test-pattern index of the presented set, 0..3.
- o_zero  out  1  all presented syndromes are zero (no error for this pattern).
- o_valid  out  1  presented set is valid; held until accepted.
- i_ready  in  1  solver accepts the set when o_valid && i_ready.
- o_done  out  1  one-cycle pulse after the last pattern of the codeword is accepted.
- o_err  out  1  sticky flag: i_valid arrived while not expecting a bundle.

## Operation
- States: IDLE, HOLD_A, HOLD_B, REQ, WAIT.
- IDLE: on i_valid, latch i_mode/i_code (cfg), the bundle, bundle counter = 0, and pattern index = 0; go to HOLD_A. cfg is frozen until return to IDLE.
- HOLD_A: o_valid=1.
  - cfg t=4, or mode 0: o_S1..o_S8 = the latched S1..S8. In the t=2 case, o_S5..o_S8 are forced to 0.
  - cfg mode 1 t=2: o_S1..o_S4 = the latched S1..S4, o_S5..o_S8 = 0.
- HOLD_A on accept:
  - mode 1 t=2: go to HOLD_B.
  - Otherwise, if this is the last bundle: go to IDLE and pulse o_done.
  - Otherwise: go to REQ.
- HOLD_B: o_S1..o_S4 = the latched S5..S4+4, o_S5..o_S8 = 0, o_tp_idx = HOLD_A idx + 1. On accept, go to REQ, or to IDLE and pulse o_done if this is the last bundle.
- Bundles per codeword: mode 0 → 1; mode 1 t=4 → 4 (idx 0,1,2,3); mode 1 t=2 → 2 (idx 0,1 then 2,3).
- REQ: o_next_tp=1 for exactly one cycle, increment the bundle counter, go to WAIT.
- WAIT: on i_valid, latch the bundle and go to HOLD_A. There is no timeout.
- o_zero is registered alongside the data and computed over the GF_W-bit values actually driven on o_S*.
- i_valid in HOLD_A/HOLD_B: the bundle is ignored and o_err is set. o_err clears only on reset.
- i_valid in REQ: captured exactly as in WAIT. The request has already been issued.

## Timing
- Reset values: state IDLE; o_valid, o_next_tp, o_done, o_zero, o_err = 0; o_S*, o_tp_idx = 0; cfg = 0.
- i_valid at cycle t → o_valid=1 with data at t+1.
- Accept at t, with another pattern in the same bundle → next set presented at t+1 (o_valid stays high).
- Accept at t, with the last pattern of a non-final bundle → o_next_tp at t+1, o_valid=0 from t+1.
- Accept at t, with the final pattern → o_done at t+1, IDLE at t+1. A new i_valid is accepted at t+1.
- i_ready is ignored while o_valid=0. o_S*/o_tp_idx stay stable while o_valid && !i_ready.
- Reset asserted mid-sequence → IDLE on the next edge, all outputs at reset values, no o_done.

## Structure
- Shared package holds:
  - the GF_W default;
  - the state encoding;
  - the CODE_T4 = 2'b10 constant;
  - the bundle-count function of (mode, code).
- One sub-module: syn_bundle_reg. It is an 8×GF_W enabled capture register with a zero-detect output for the selected half/full set.

## Test plan
- Mode 0, code 2'b10, i_valid with S1..S8 = 1..8, i_ready=1 → o_valid at t+1, o_S1..o_S8 = 1..8, idx 0, o_done at t+2, o_next_tp never asserted.
- Mode 1, code 2'b00, bundles {S1..S4=1..4, S5..S8=5..8} then {9..16} → sets idx0 = 1..4, idx1 = 5..8, one o_next_tp, then idx2 = 9..12, idx3 = 13..16, o_S5..o_S8 = 0 throughout, o_done once.
- Mode 1, code 2'b10, four bundles with i_ready toggling 1/0 → exactly three o_next_tp pulses, idx 0..3 in order, data stable while stalled.
- All-zero bundle in mode 0 → o_zero=1. A bundle with only S8=3 under code 2'b00 → o_zero=1, since S8 is not presented.
- i_valid during HOLD_A → bundle ignored, o_err=1 and sticky. Reset asserted in WAIT → outputs at reset values, next i_valid starts idx 0.
